if_id_fetch_stage: RTL and testbench



---
 rtl/mips_pkg.sv | 16 +
 rtl/if_id_fetch_stage_if.sv | 11 +
 rtl/if_id_fetch_stage_sat_counter.sv | 19 +
 rtl/if_id_fetch_stage.sv | 73 +++++++
 tb/tb_if_id_fetch_stage.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared pipeline definitions for the five-stage MIPS pipeline.
package mips_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_0000;

  // IF/ID pipeline register payload, shared with the ID stage and hazard unit
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc4;
    logic            valid;
  } if_id_t;

endpackage

// File: rtl/if_id_fetch_stage_if.sv
// Instruction-memory fetch bus: address out from the fetch stage, instruction back.
interface if_id_fetch_stage_if #(
  parameter int unsigned PC_WIDTH    = 32,
  parameter int unsigned INSTR_WIDTH = 32
);
  logic [PC_WIDTH-1:0]    imem_addr;
  logic [INSTR_WIDTH-1:0] imem_rdata;

  modport master (output imem_addr, input  imem_rdata);
  modport slave  (input  imem_addr, output imem_rdata);
endinterface

// File: rtl/if_id_fetch_stage_sat_counter.sv
// Saturating up-counter with synchronous active-low clear.
module sat_counter #(
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != {CNT_WIDTH{1'b1}})) begin
      count <= count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/if_id_fetch_stage.sv
// Fetch stage: owns the PC, drives instruction fetch, and loads the IF/ID register
// with stall hold, taken-branch redirect/flush and saturating debug statistics.
module if_id_fetch_stage #(
  parameter int unsigned           PC_WIDTH    = 32,
  parameter int unsigned           INSTR_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0]   RESET_PC    = PC_WIDTH'(mips_pkg::RESET_PC),
  parameter int unsigned           CNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   PCWrite,
  input  logic                   IF_ID_write,
  input  logic                   branch_taken,
  input  logic [PC_WIDTH-1:0]    branch_target,
  if_id_fetch_stage_if.master    imem,
  output logic [INSTR_WIDTH-1:0] IF_ID_instr,
  output logic [PC_WIDTH-1:0]    IF_ID_pc4,
  output logic                   IF_ID_valid,
  output logic [CNT_WIDTH-1:0]   stall_count,
  output logic [CNT_WIDTH-1:0]   flush_count
);

  localparam logic [INSTR_WIDTH-1:0] NOP = INSTR_WIDTH'(mips_pkg::NOP_INSTR);

  logic [PC_WIDTH-1:0] pc;
  logic [PC_WIDTH-1:0] pc_plus4_c;
  logic                stall_inc_c;

  assign pc_plus4_c     = pc + PC_WIDTH'(4);
  assign imem.imem_addr = pc;

  // A redirect takes precedence, so a stall cycle that also redirects is not a stall
  assign stall_inc_c = !branch_taken && !PCWrite;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      IF_ID_instr <= NOP;
      IF_ID_pc4   <= '0;
      IF_ID_valid <= 1'b0;
    end else if (branch_taken) begin
      pc          <= branch_target;
      IF_ID_instr <= NOP;
      IF_ID_pc4   <= '0;
      IF_ID_valid <= 1'b0;
    end else begin
      // PC and IF/ID hold independently so mixed stall controls behave per register
      if (PCWrite) begin
        pc <= pc_plus4_c;
      end
      if (IF_ID_write) begin
        IF_ID_instr <= imem.imem_rdata;
        IF_ID_pc4   <= pc_plus4_c;
        IF_ID_valid <= 1'b1;
      end
    end
  end

  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_inc_c),
    .count (stall_count)
  );

  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (branch_taken),
    .count (flush_count)
  );

endmodule

// File: tb/tb_if_id_fetch_stage.sv
// Directed self-checking bench for if_id_fetch_stage (CNT_WIDTH=4 to reach saturation).
module tb_if_id_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pc_write;
  logic        if_id_write;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        use_const;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic [3:0]  stall_count;
  logic [3:0]  flush_count;

  int tests = 0;
  int fails = 0;

  if_id_fetch_stage_if #(.PC_WIDTH(32), .INSTR_WIDTH(32)) bus ();

  // Instruction memory: fixed word, or a word tagged with the low address bits
  assign bus.imem_rdata = use_const ? 32'h2008_0005 : {16'hABCD, bus.imem_addr[15:0]};

  if_id_fetch_stage #(
    .PC_WIDTH    (32),
    .INSTR_WIDTH (32),
    .RESET_PC    (32'h0000_0000),
    .CNT_WIDTH   (4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .PCWrite       (pc_write),
    .IF_ID_write   (if_id_write),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem          (bus),
    .IF_ID_instr   (if_id_instr),
    .IF_ID_pc4     (if_id_pc4),
    .IF_ID_valid   (if_id_valid),
    .stall_count   (stall_count),
    .flush_count   (flush_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_ifid(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                          input logic [31:0] pc4, input logic valid);
    chk({tag, "_pc"},    bus.imem_addr, pc);
    chk({tag, "_instr"}, if_id_instr,   instr);
    chk({tag, "_pc4"},   if_id_pc4,     pc4);
    chk({tag, "_valid"}, 32'(if_id_valid), 32'(valid));
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; pc_write = 1'b1; if_id_write = 1'b1;
    branch_taken = 1'b0; branch_target = '0; use_const = 1'b1;

    // Reset, then release
    step(); step();
    chk_ifid("reset", 32'h0, 32'h0, 32'h0, 1'b0);
    chk("reset_stall_cnt", 32'(stall_count), 32'd0);
    chk("reset_flush_cnt", 32'(flush_count), 32'd0);
    rst_n = 1'b1;
    step();
    chk_ifid("run1", 32'h4, 32'h2008_0005, 32'h4, 1'b1);
    step();
    chk_ifid("run2", 32'h8, 32'h2008_0005, 32'h8, 1'b1);

    // Load-use stall for two cycles at PC=8
    use_const = 1'b0;
    pc_write = 1'b0; if_id_write = 1'b0;
    step();
    chk_ifid("stall1", 32'h8, 32'h2008_0005, 32'h8, 1'b1);
    step();
    chk_ifid("stall2", 32'h8, 32'h2008_0005, 32'h8, 1'b1);
    chk("stall_cnt2", 32'(stall_count), 32'd2);
    pc_write = 1'b1; if_id_write = 1'b1;
    step();
    chk_ifid("release", 32'hC, 32'hABCD_0008, 32'hC, 1'b1);
    step();
    chk_ifid("run3", 32'h10, 32'hABCD_000C, 32'h10, 1'b1);

    // Redirect at PC=16
    branch_taken = 1'b1; branch_target = 32'h40;
    step();
    chk_ifid("redir", 32'h40, 32'h0, 32'h0, 1'b0);
    chk("redir_flush_cnt", 32'(flush_count), 32'd1);
    branch_taken = 1'b0;
    step();
    chk_ifid("target", 32'h44, 32'hABCD_0040, 32'h44, 1'b1);

    // Redirect and stall together: redirect wins, no stall counted
    branch_taken = 1'b1; branch_target = 32'h100; pc_write = 1'b0; if_id_write = 1'b0;
    step();
    chk_ifid("redir_stall", 32'h100, 32'h0, 32'h0, 1'b0);
    chk("rs_flush_cnt", 32'(flush_count), 32'd2);
    chk("rs_stall_cnt", 32'(stall_count), 32'd2);

    // Mixed controls: PC held, IF/ID loads
    branch_taken = 1'b0; pc_write = 1'b0; if_id_write = 1'b1;
    step();
    chk_ifid("mix_pc_hold", 32'h100, 32'hABCD_0100, 32'h104, 1'b1);
    chk("mix_stall_cnt", 32'(stall_count), 32'd3);
    // Mixed controls: PC advances, IF/ID holds
    pc_write = 1'b1; if_id_write = 1'b0;
    step();
    chk_ifid("mix_ifid_hold", 32'h104, 32'hABCD_0100, 32'h104, 1'b1);
    chk("mix2_stall_cnt", 32'(stall_count), 32'd3);
    if_id_write = 1'b1;

    // Wraparound
    branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC;
    step();
    chk("wrap_preload_pc", bus.imem_addr, 32'hFFFF_FFFC);
    chk("wrap_flush_cnt", 32'(flush_count), 32'd3);
    branch_taken = 1'b0;
    step();
    chk_ifid("wrap", 32'h0, 32'hABCD_FFFC, 32'h0, 1'b1);

    // Saturation of the 4-bit stall counter
    pc_write = 1'b0; if_id_write = 1'b0;
    for (int i = 0; i < 12; i++) step();
    chk("sat_reach", 32'(stall_count), 32'd15);
    for (int i = 0; i < 8; i++) step();
    chk("sat_hold", 32'(stall_count), 32'd15);
    chk("sat_pc", bus.imem_addr, 32'h0);

    // Reset during stall and redirect
    rst_n = 1'b0; branch_taken = 1'b1; branch_target = 32'h200;
    step();
    chk_ifid("mid_reset", 32'h0, 32'h0, 32'h0, 1'b0);
    chk("mid_reset_stall_cnt", 32'(stall_count), 32'd0);
    chk("mid_reset_flush_cnt", 32'(flush_count), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
